// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_tx engine among NUM_REQ
// requesters, with per-requester chip select, setup/hold/gap timing and a
// BUSY watchdog.
// Ports: clk, rst (sync, active-high); req_vld/req_data/req_len in,
// req_ack/req_done/req_err pulses out; eng_tx_data/eng_length/eng_tx_vld
// to the engine, eng_tx_rdy/eng_tx_eot from it; cs_n, owner, busy status.
module spi_tx_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int SPI_TX_WIDTH    = 32,
    parameter int LENGTH_TRANSMIT = 5,
    parameter int CS_SETUP        = 2,
    parameter int CS_HOLD         = 2,
    parameter int GAP             = 1,
    parameter int TIMEOUT         = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_vld,
    input  logic [NUM_REQ*SPI_TX_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ*LENGTH_TRANSMIT-1:0] req_len,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic [NUM_REQ-1:0]                 req_err,
    output logic [SPI_TX_WIDTH-1:0]            eng_tx_data,
    output logic [LENGTH_TRANSMIT-1:0]         eng_length,
    output logic                               eng_tx_vld,
    input  logic                               eng_tx_rdy,
    input  logic                               eng_tx_eot,
    output logic [NUM_REQ-1:0]                 cs_n,
    output logic [$clog2(NUM_REQ)-1:0]         owner,
    output logic                               busy
);

    localparam int OW      = $clog2(NUM_REQ);
    localparam int SETUP_N = (CS_SETUP < 1) ? 1 : CS_SETUP;
    localparam int HOLD_N  = (CS_HOLD < 1) ? 1 : CS_HOLD;
    localparam int GAP_N   = (GAP < 1) ? 1 : GAP;
    localparam int TO_N    = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int M1      = (SETUP_N > HOLD_N) ? SETUP_N : HOLD_N;
    localparam int M2      = (GAP_N > TO_N) ? GAP_N : TO_N;
    localparam int CMAX    = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_BUSY,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t                     state;
    logic [CW-1:0]              cnt;
    logic [OW-1:0]              ptr;
    logic                       zero_pend;

    logic                       gnt_hit;
    logic [OW-1:0]              gnt_idx;
    logic [OW-1:0]              rr_j;
    logic [NUM_REQ-1:0]         gnt_oh;
    logic [NUM_REQ-1:0]         owner_oh;
    logic [SPI_TX_WIDTH-1:0]    sel_data;
    logic [LENGTH_TRANSMIT-1:0] sel_len;

    // Walk from ptr+NUM_REQ down to ptr+1 so the nearest set bit after
    // the pointer is the last one written and wins.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        rr_j    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_j = OW'((int'(ptr) + k) % NUM_REQ);
            if (req_vld[rr_j]) begin
                gnt_hit = 1'b1;
                gnt_idx = rr_j;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == OW'(i)) begin
                sel_data = req_data[i*SPI_TX_WIDTH +: SPI_TX_WIDTH];
                sel_len  = req_len[i*LENGTH_TRANSMIT +: LENGTH_TRANSMIT];
            end
        end
    end

    assign gnt_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
    assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ptr         <= OW'(NUM_REQ - 1);
            zero_pend   <= 1'b0;
            req_ack     <= '0;
            req_done    <= '0;
            req_err     <= '0;
            eng_tx_data <= '0;
            eng_length  <= '0;
            eng_tx_vld  <= 1'b0;
            cs_n        <= '1;
            owner       <= '0;
            busy        <= 1'b0;
        end else begin
            req_ack  <= '0;
            req_done <= '0;
            req_err  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (gnt_hit) begin
                        req_ack     <= gnt_oh;
                        owner       <= gnt_idx;
                        ptr         <= gnt_idx;
                        eng_tx_data <= sel_data;
                        eng_length  <= sel_len;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        if (sel_len == '0) begin
                            // Empty frame: no CS, no engine; done in GAP.
                            zero_pend <= 1'b1;
                            state     <= ST_GAP;
                        end else begin
                            cs_n  <= ~gnt_oh;
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == CW'(SETUP_N - 1)) begin
                        cnt        <= '0;
                        eng_tx_vld <= 1'b1;
                        state      <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (eng_tx_rdy) begin
                        eng_tx_vld <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (eng_tx_eot) begin
                        req_done <= owner_oh;
                        cnt      <= '0;
                        state    <= ST_HOLD;
                    end else if (cnt == CW'(TO_N - 1)) begin
                        req_err <= owner_oh;
                        cnt     <= '0;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == CW'(HOLD_N - 1)) begin
                        cs_n  <= '1;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (zero_pend) begin
                        req_done  <= owner_oh;
                        zero_pend <= 1'b0;
                    end
                    if (cnt == CW'(GAP_N - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomised directed bench for spi_tx_arbiter: a round-robin model plus
// timing expectations derived from the setup/hold/gap/timeout parameters.
module tb_spi_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int L  = 5;
    localparam int S  = 2;
    localparam int H  = 2;
    localparam int G  = 1;
    localparam int TO = 1024;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_vld;
    logic [N*W-1:0]       req_data;
    logic [N*L-1:0]       req_len;
    logic [N-1:0]         req_ack;
    logic [N-1:0]         req_done;
    logic [N-1:0]         req_err;
    logic [W-1:0]         eng_tx_data;
    logic [L-1:0]         eng_length;
    logic                 eng_tx_vld;
    logic                 eng_tx_rdy;
    logic                 eng_tx_eot;
    logic [N-1:0]         cs_n;
    logic [$clog2(N)-1:0] owner;
    logic                 busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int rr_ptr = N - 1;
    logic [N-1:0] all1 = '1;
    logic [N-1:0] none = '0;

    spi_tx_arbiter #(
        .NUM_REQ(N), .SPI_TX_WIDTH(W), .LENGTH_TRANSMIT(L),
        .CS_SETUP(S), .CS_HOLD(H), .GAP(G), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_data(req_data), .req_len(req_len),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .eng_tx_data(eng_tx_data), .eng_length(eng_length),
        .eng_tx_vld(eng_tx_vld), .eng_tx_rdy(eng_tx_rdy),
        .eng_tx_eot(eng_tx_eot), .cs_n(cs_n), .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        chk("idle_wait", {63'd0, busy}, 64'd0);
    endtask

    // fl < 0 picks random nonzero lengths; fl == 0 forces empty frames.
    task automatic frame(input logic [N-1:0] mask, input bit keep,
                         input logic [W-1:0] fd, input bit use_fd,
                         input int fl, input int rdy_dly,
                         input int eot_dly, input bit wdog,
                         input bit rst_busy, input bit stray);
        int w;
        bit early;
        logic [N-1:0] oh, nh;
        logic [W-1:0] d;
        logic [L-1:0] l;
        wait_idle();
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = $urandom;
            req_len[i*L +: L]  = (fl < 0) ? L'($urandom_range(1, 31))
                                          : L'(fl);
        end
        w = pick(rr_ptr, mask);
        if (use_fd) req_data[w*W +: W] = fd;
        req_vld = mask;
        rr_ptr  = w;
        oh = '0;
        oh[w] = 1'b1;
        nh = ~oh;
        d = req_data[w*W +: W];
        l = req_len[w*L +: L];
        step();
        chk("ack", req_ack, oh);
        chk("owner", owner, w);
        chk("busy_on", busy, 1);
        if (!keep) req_vld[w] = 1'b0;
        if (l == '0) begin
            chk("zl_cs", cs_n, all1);
            step();
            chk("zl_done", req_done, oh);
            chk("zl_ack_clr", req_ack, none);
            chk("zl_cs2", cs_n, all1);
            chk("zl_vld", eng_tx_vld, 0);
            return;
        end
        for (int s = 0; s < S; s++) begin
            chk("setup_cs", cs_n, nh);
            chk("setup_vld", eng_tx_vld, 0);
            eng_tx_eot = stray && (s == 0);
            step();
            eng_tx_eot = 1'b0;
        end
        chk("issue_vld", eng_tx_vld, 1);
        chk("issue_data", eng_tx_data, d);
        chk("issue_len", eng_length, l);
        for (int r = 0; r < rdy_dly; r++) begin
            step();
            chk("bp_vld", eng_tx_vld, 1);
            chk("bp_data", eng_tx_data, d);
        end
        eng_tx_rdy = 1'b1;
        step();
        eng_tx_rdy = 1'b0;
        chk("vld_drop", eng_tx_vld, 0);
        chk("busy_cs", cs_n, nh);
        if (rst_busy) begin
            repeat (3) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst_cs", cs_n, all1);
            chk("rst_busy", busy, 0);
            chk("rst_vld", eng_tx_vld, 0);
            chk("rst_owner", owner, 0);
            chk("rst_pulses", {req_ack, req_done, req_err}, 0);
            rr_ptr = N - 1;
            return;
        end
        if (wdog) begin
            early = 1'b0;
            for (int n = 1; n <= TO; n++) begin
                step();
                if (n < TO) early |= (req_err != 0) || (req_done != 0);
            end
            chk("wd_early", early, 0);
            chk("wd_err", req_err, oh);
            chk("wd_nodone", req_done, none);
        end else begin
            repeat (eot_dly) step();
            eng_tx_eot = 1'b1;
            step();
            eng_tx_eot = 1'b0;
            chk("done", req_done, oh);
            chk("noerr", req_err, none);
        end
        chk("hold_cs", cs_n, nh);
        repeat (H - 1) begin
            step();
            chk("hold_cs", cs_n, nh);
            chk("hold_done_clr", req_done, none);
        end
        step();
        chk("rel_cs", cs_n, all1);
        chk("gap_busy", busy, 1);
        repeat (G - 1) step();
        step();
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_vld    = '0;
        req_data   = '0;
        req_len    = '0;
        eng_tx_rdy = 1'b0;
        eng_tx_eot = 1'b0;
        repeat (3) step();
        chk("r_cs", cs_n, all1);
        chk("r_vld", eng_tx_vld, 0);
        chk("r_pulses", {req_ack, req_done, req_err}, 0);
        chk("r_busy", busy, 0);
        chk("r_data", eng_tx_data, 0);
        chk("r_len", eng_length, 0);
        chk("r_owner", owner, 0);
        rst = 1'b0;
        step();

        // Held all-request round robin: grants 0,1,2,3,0.
        for (int f = 0; f < 5; f++)
            frame(4'b1111, 1'b1, '0, 1'b0, -1, $urandom_range(0, 3),
                  $urandom_range(0, 4), 1'b0, 1'b0, f == 0);
        req_vld = '0;

        frame(4'b0100, 1'b0, 32'hA5A5_0F0F, 1'b1, 8, 2, 3,
              1'b0, 1'b0, 1'b0);
        frame(4'b0010, 1'b0, '0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 6; f++)
            frame(4'($urandom_range(1, 15)), 1'b0, '0, 1'b0, -1,
                  $urandom_range(0, 3), $urandom_range(0, 5),
                  1'b0, 1'b0, 1'b0);

        frame(4'b1000, 1'b0, '0, 1'b0, -1, 1, 0, 1'b1, 1'b0, 1'b0);
        frame(4'b0001, 1'b0, '0, 1'b0, -1, 20, 0, 1'b0, 1'b1, 1'b0);
        frame(4'b1111, 1'b0, '0, 1'b0, -1, 0, 1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
